reorder_buffer: RTL and testbench

Parametrised in-order-commit reorder buffer for the out-of-order RV32I core, sitting between the decoder (allocation, operand queries), the RS/LSB result buses (writeback) and the register file/LSB (commit). Generalises the earlier fixed-size ROB. Depth and type width are parameters. Adds:
- same-cycle result bypass on operand queries;
- branch-misprediction detection at commit, with a one-cycle pipeline flush and redirect PC;
- store-commit and halt signalling.

---
 rtl/reorder_buffer_if.sv | 59 +++++
 rtl/reorder_buffer.sv | 198 +++++++++++++++++++
 tb/tb_reorder_buffer.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_if.sv
// Decoder / result-bus / commit signal bundle for the reorder buffer.
// The ROB itself takes the slave side; the core (or a bench) takes the master side.
interface reorder_buffer_if #(
    parameter int IDX_W  = 4,
    parameter int TYPE_W = 2
);
    logic              rob_full;
    logic [IDX_W-1:0]  rob_free_id;

    logic              alloc_valid;
    logic [TYPE_W-1:0] alloc_type;
    logic [4:0]        alloc_rd;
    logic [31:0]       alloc_value;
    logic [31:0]       alloc_pc;
    logic              alloc_done;

    logic              rs_valid;
    logic [IDX_W-1:0]  rs_id;
    logic [31:0]       rs_value;
    logic              lsb_valid;
    logic [IDX_W-1:0]  lsb_id;
    logic [31:0]       lsb_value;

    logic [IDX_W-1:0]  qry1_id;
    logic [IDX_W-1:0]  qry2_id;
    logic              qry1_ready;
    logic              qry2_ready;
    logic [31:0]       qry1_value;
    logic [31:0]       qry2_value;

    logic              commit_valid;
    logic [IDX_W-1:0]  commit_id;
    logic [4:0]        commit_rd;
    logic [31:0]       commit_value;
    logic              commit_store;
    logic              rob_clear;
    logic [31:0]       clear_pc;
    logic              halt;

    modport master (
        input  rob_full, rob_free_id,
        output alloc_valid, alloc_type, alloc_rd, alloc_value, alloc_pc, alloc_done,
        output rs_valid, rs_id, rs_value, lsb_valid, lsb_id, lsb_value,
        output qry1_id, qry2_id,
        input  qry1_ready, qry2_ready, qry1_value, qry2_value,
        input  commit_valid, commit_id, commit_rd, commit_value, commit_store,
        input  rob_clear, clear_pc, halt
    );

    modport slave (
        output rob_full, rob_free_id,
        input  alloc_valid, alloc_type, alloc_rd, alloc_value, alloc_pc, alloc_done,
        input  rs_valid, rs_id, rs_value, lsb_valid, lsb_id, lsb_value,
        input  qry1_id, qry2_id,
        output qry1_ready, qry2_ready, qry1_value, qry2_value,
        output commit_valid, commit_id, commit_rd, commit_value, commit_store,
        output rob_clear, clear_pc, halt
    );
endinterface

// File: rtl/reorder_buffer.sv
// In-order-commit reorder buffer: circular entry array with result bypass on queries,
// branch-mispredict flush at commit, store-commit and sticky halt signalling.
module reorder_buffer #(
    parameter int DEPTH  = 16,
    parameter int IDX_W  = 4,
    parameter int TYPE_W = 2
) (
    input logic             clk_in,
    input logic             rst_in,
    input logic             rdy_in,
    reorder_buffer_if.slave rob
);

    localparam logic [TYPE_W-1:0] TYPE_REG    = TYPE_W'(0);
    localparam logic [TYPE_W-1:0] TYPE_STORE  = TYPE_W'(1);
    localparam logic [TYPE_W-1:0] TYPE_BRANCH = TYPE_W'(2);
    localparam logic [TYPE_W-1:0] TYPE_HALT   = TYPE_W'(3);

    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [DEPTH-1:0]  done_q, done_d;
    logic [TYPE_W-1:0] type_q  [DEPTH];
    logic [TYPE_W-1:0] type_d  [DEPTH];
    logic [4:0]        rd_q    [DEPTH];
    logic [4:0]        rd_d    [DEPTH];
    logic [31:0]       value_q [DEPTH];
    logic [31:0]       value_d [DEPTH];
    logic [31:0]       pred_q  [DEPTH];
    logic [31:0]       pred_d  [DEPTH];

    logic [IDX_W-1:0]  head_q, head_d;
    logic [IDX_W-1:0]  tail_q, tail_d;
    logic [IDX_W:0]    count_q, count_d;

    logic              commit_valid_q, commit_valid_d;
    logic [IDX_W-1:0]  commit_id_q, commit_id_d;
    logic [4:0]        commit_rd_q, commit_rd_d;
    logic [31:0]       commit_value_q, commit_value_d;
    logic              commit_store_q, commit_store_d;
    logic              rob_clear_q, rob_clear_d;
    logic [31:0]       clear_pc_q, clear_pc_d;
    logic              halt_q, halt_d;

    logic              full;
    logic              alloc_fire;
    logic              commit_fire;
    logic              mispredict;

    assign full        = (count_q == (IDX_W+1)'(DEPTH));
    assign alloc_fire  = rob.alloc_valid && !full && !rob_clear_q;
    assign commit_fire = (count_q != '0) && done_q[head_q] && !halt_q && !rob_clear_q;
    assign mispredict  = (type_q[head_q] == TYPE_BRANCH) && (value_q[head_q] != pred_q[head_q]);

    always_comb begin
        busy_d         = busy_q;
        done_d         = done_q;
        type_d         = type_q;
        rd_d           = rd_q;
        value_d        = value_q;
        pred_d         = pred_q;
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q + (IDX_W+1)'(alloc_fire) - (IDX_W+1)'(commit_fire);
        commit_valid_d = 1'b0;
        commit_id_d    = commit_id_q;
        commit_rd_d    = commit_rd_q;
        commit_value_d = commit_value_q;
        commit_store_d = commit_store_q;
        rob_clear_d    = 1'b0;
        clear_pc_d     = clear_pc_q;
        halt_d         = halt_q;

        if (alloc_fire) begin
            busy_d[tail_q]  = 1'b1;
            done_d[tail_q]  = rob.alloc_done;
            type_d[tail_q]  = rob.alloc_type;
            rd_d[tail_q]    = rob.alloc_rd;
            value_d[tail_q] = rob.alloc_value;
            pred_d[tail_q]  = rob.alloc_value;
            tail_d          = tail_q + IDX_W'(1);
        end

        // Buses never hit the tail slot being allocated: it is not busy yet.
        if (!rob_clear_q) begin
            if (rob.rs_valid && busy_q[rob.rs_id]) begin
                done_d[rob.rs_id]  = 1'b1;
                value_d[rob.rs_id] = rob.rs_value;
            end
            if (rob.lsb_valid && busy_q[rob.lsb_id]) begin
                done_d[rob.lsb_id]  = 1'b1;
                value_d[rob.lsb_id] = rob.lsb_value;
            end
        end

        if (commit_fire) begin
            busy_d[head_q] = 1'b0;
            done_d[head_q] = 1'b0;
            head_d         = head_q + IDX_W'(1);
            commit_valid_d = 1'b1;
            commit_id_d    = head_q;
            commit_rd_d    = (type_q[head_q] == TYPE_REG) ? rd_q[head_q] : 5'd0;
            commit_value_d = value_q[head_q];
            commit_store_d = (type_q[head_q] == TYPE_STORE);
            if (type_q[head_q] == TYPE_HALT) begin
                halt_d = 1'b1;
            end
            // Flush overrides any allocation or writeback landing on the same edge.
            if (mispredict) begin
                rob_clear_d = 1'b1;
                clear_pc_d  = value_q[head_q];
                busy_d      = '0;
                done_d      = '0;
                head_d      = '0;
                tail_d      = '0;
                count_d     = '0;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            busy_q         <= '0;
            done_q         <= '0;
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            commit_valid_q <= 1'b0;
            commit_id_q    <= '0;
            commit_rd_q    <= '0;
            commit_value_q <= '0;
            commit_store_q <= 1'b0;
            rob_clear_q    <= 1'b0;
            clear_pc_q     <= '0;
            halt_q         <= 1'b0;
        end else if (rdy_in) begin
            busy_q         <= busy_d;
            done_q         <= done_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            commit_valid_q <= commit_valid_d;
            commit_id_q    <= commit_id_d;
            commit_rd_q    <= commit_rd_d;
            commit_value_q <= commit_value_d;
            commit_store_q <= commit_store_d;
            rob_clear_q    <= rob_clear_d;
            clear_pc_q     <= clear_pc_d;
            halt_q         <= halt_d;
        end
    end

    // Payload fields are only meaningful while busy, so they carry no reset.
    always_ff @(posedge clk_in) begin
        if (rdy_in) begin
            type_q  <= type_d;
            rd_q    <= rd_d;
            value_q <= value_d;
            pred_q  <= pred_d;
        end
    end

    always_comb begin
        rob.qry1_ready = done_q[rob.qry1_id];
        rob.qry1_value = value_q[rob.qry1_id];
        if (rob.lsb_valid && rob.lsb_id == rob.qry1_id) begin
            rob.qry1_ready = 1'b1;
            rob.qry1_value = rob.lsb_value;
        end
        if (rob.rs_valid && rob.rs_id == rob.qry1_id) begin
            rob.qry1_ready = 1'b1;
            rob.qry1_value = rob.rs_value;
        end
    end

    always_comb begin
        rob.qry2_ready = done_q[rob.qry2_id];
        rob.qry2_value = value_q[rob.qry2_id];
        if (rob.lsb_valid && rob.lsb_id == rob.qry2_id) begin
            rob.qry2_ready = 1'b1;
            rob.qry2_value = rob.lsb_value;
        end
        if (rob.rs_valid && rob.rs_id == rob.qry2_id) begin
            rob.qry2_ready = 1'b1;
            rob.qry2_value = rob.rs_value;
        end
    end

    assign rob.rob_full     = full;
    assign rob.rob_free_id  = tail_q;
    assign rob.commit_valid = commit_valid_q;
    assign rob.commit_id    = commit_id_q;
    assign rob.commit_rd    = commit_rd_q;
    assign rob.commit_value = commit_value_q;
    assign rob.commit_store = commit_store_q;
    assign rob.rob_clear    = rob_clear_q;
    assign rob.clear_pc     = clear_pc_q;
    assign rob.halt         = halt_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: allocation/commit order, out-of-order writeback,
// full/wrap, query bypass, branch flush, halt and rdy_in stalls.
module tb_reorder_buffer;

    logic clk = 1'b0;
    logic rst;
    logic rdy;
    int   n_cmp = 0;
    int   n_err = 0;

    reorder_buffer_if #(.IDX_W(4), .TYPE_W(2)) rob_if ();

    reorder_buffer #(.DEPTH(16), .IDX_W(4), .TYPE_W(2)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .rdy_in (rdy),
        .rob    (rob_if)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        rob_if.alloc_valid = 1'b0;
        rob_if.alloc_type  = 2'd0;
        rob_if.alloc_rd    = 5'd0;
        rob_if.alloc_value = 32'h0;
        rob_if.alloc_pc    = 32'h0;
        rob_if.alloc_done  = 1'b0;
        rob_if.rs_valid    = 1'b0;
        rob_if.rs_id       = 4'd0;
        rob_if.rs_value    = 32'h0;
        rob_if.lsb_valid   = 1'b0;
        rob_if.lsb_id      = 4'd0;
        rob_if.lsb_value   = 32'h0;
        rob_if.qry1_id     = 4'd0;
        rob_if.qry2_id     = 4'd0;
    endtask

    task automatic set_alloc(input logic [1:0] t, input logic [4:0] rd, input logic [31:0] v, input logic d);
        rob_if.alloc_valid = 1'b1;
        rob_if.alloc_type  = t;
        rob_if.alloc_rd    = rd;
        rob_if.alloc_value = v;
        rob_if.alloc_pc    = 32'h1000 + {27'd0, rd};
        rob_if.alloc_done  = d;
    endtask

    task automatic do_reset;
        rdy = 1'b1;
        rst = 1'b0;
        idle();
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset;
        do_reset();
        #1;
        n_cmp++; if (rob_if.rob_full !== 1'b0) begin n_err++; $display("FAIL reset_full got=%b exp=0", rob_if.rob_full); end
        n_cmp++; if (rob_if.rob_free_id !== 4'd0) begin n_err++; $display("FAIL reset_free_id got=%0d exp=0", rob_if.rob_free_id); end
        n_cmp++; if (rob_if.commit_valid !== 1'b0) begin n_err++; $display("FAIL reset_commit_valid got=%b exp=0", rob_if.commit_valid); end
        n_cmp++; if (rob_if.commit_value !== 32'h0) begin n_err++; $display("FAIL reset_commit_value got=%h exp=0", rob_if.commit_value); end
        n_cmp++; if (rob_if.rob_clear !== 1'b0) begin n_err++; $display("FAIL reset_rob_clear got=%b exp=0", rob_if.rob_clear); end
        n_cmp++; if (rob_if.clear_pc !== 32'h0) begin n_err++; $display("FAIL reset_clear_pc got=%h exp=0", rob_if.clear_pc); end
        n_cmp++; if (rob_if.halt !== 1'b0) begin n_err++; $display("FAIL reset_halt got=%b exp=0", rob_if.halt); end
        n_cmp++; if (rob_if.qry1_ready !== 1'b0) begin n_err++; $display("FAIL reset_qry1_ready got=%b exp=0", rob_if.qry1_ready); end
    endtask

    task automatic test_alloc_commit;
        set_alloc(2'd0, 5'd5, 32'h10, 1'b1);
        tick();
        n_cmp++; if (rob_if.rob_free_id !== 4'd1) begin n_err++; $display("FAIL ac_free_id1 got=%0d exp=1", rob_if.rob_free_id); end
        n_cmp++; if (rob_if.commit_valid !== 1'b0) begin n_err++; $display("FAIL ac_no_commit_yet got=%b exp=0", rob_if.commit_valid); end
        set_alloc(2'd0, 5'd6, 32'h0, 1'b0);
        tick();
        n_cmp++; if (rob_if.rob_free_id !== 4'd2) begin n_err++; $display("FAIL ac_free_id2 got=%0d exp=2", rob_if.rob_free_id); end
        n_cmp++; if (rob_if.commit_valid !== 1'b1) begin n_err++; $display("FAIL ac_commit0_valid got=%b exp=1", rob_if.commit_valid); end
        n_cmp++; if (rob_if.commit_id !== 4'd0) begin n_err++; $display("FAIL ac_commit0_id got=%0d exp=0", rob_if.commit_id); end
        n_cmp++; if (rob_if.commit_rd !== 5'd5) begin n_err++; $display("FAIL ac_commit0_rd got=%0d exp=5", rob_if.commit_rd); end
        n_cmp++; if (rob_if.commit_value !== 32'h10) begin n_err++; $display("FAIL ac_commit0_value got=%h exp=10", rob_if.commit_value); end
        set_alloc(2'd1, 5'd0, 32'h0, 1'b0);
        tick();
        n_cmp++; if (rob_if.rob_free_id !== 4'd3) begin n_err++; $display("FAIL ac_free_id3 got=%0d exp=3", rob_if.rob_free_id); end
        n_cmp++; if (rob_if.commit_valid !== 1'b0) begin n_err++; $display("FAIL ac_pulse_single got=%b exp=0", rob_if.commit_valid); end
        idle();
        tick();
        n_cmp++; if (rob_if.commit_valid !== 1'b0) begin n_err++; $display("FAIL ac_head_stall got=%b exp=0", rob_if.commit_valid); end
    endtask

    task automatic test_ooo_writeback;
        rob_if.lsb_valid = 1'b1; rob_if.lsb_id = 4'd2; rob_if.lsb_value = 32'h55;
        tick();
        idle();
        rob_if.qry2_id = 4'd2;
        #1;
        n_cmp++; if (rob_if.commit_valid !== 1'b0) begin n_err++; $display("FAIL ooo_no_commit got=%b exp=0", rob_if.commit_valid); end
        n_cmp++; if (rob_if.qry2_ready !== 1'b1 || rob_if.qry2_value !== 32'h55) begin n_err++; $display("FAIL ooo_qry2_stored got=%b/%h exp=1/55", rob_if.qry2_ready, rob_if.qry2_value); end
        rob_if.rs_valid = 1'b1; rob_if.rs_id = 4'd1; rob_if.rs_value = 32'h2A;
        tick();
        idle();
        tick();
        n_cmp++; if (rob_if.commit_valid !== 1'b1 || rob_if.commit_id !== 4'd1) begin n_err++; $display("FAIL ooo_commit1 got=%b/%0d exp=1/1", rob_if.commit_valid, rob_if.commit_id); end
        n_cmp++; if (rob_if.commit_rd !== 5'd6 || rob_if.commit_value !== 32'h2A) begin n_err++; $display("FAIL ooo_commit1_data got=%0d/%h exp=6/2a", rob_if.commit_rd, rob_if.commit_value); end
        n_cmp++; if (rob_if.commit_store !== 1'b0) begin n_err++; $display("FAIL ooo_commit1_store got=%b exp=0", rob_if.commit_store); end
        tick();
        n_cmp++; if (rob_if.commit_valid !== 1'b1 || rob_if.commit_id !== 4'd2) begin n_err++; $display("FAIL ooo_commit2 got=%b/%0d exp=1/2", rob_if.commit_valid, rob_if.commit_id); end
        n_cmp++; if (rob_if.commit_store !== 1'b1 || rob_if.commit_rd !== 5'd0) begin n_err++; $display("FAIL ooo_commit2_store got=%b/%0d exp=1/0", rob_if.commit_store, rob_if.commit_rd); end
        tick();
        n_cmp++; if (rob_if.commit_valid !== 1'b0) begin n_err++; $display("FAIL ooo_drained got=%b exp=0", rob_if.commit_valid); end
    endtask

    task automatic test_full_wrap;
        for (int i = 0; i < 16; i++) begin
            set_alloc(2'd0, 5'(i + 1), 32'(i), 1'b0);
            tick();
            if (i == 12) begin
                n_cmp++; if (rob_if.rob_free_id !== 4'd0) begin n_err++; $display("FAIL fw_wrap_to_0 got=%0d exp=0", rob_if.rob_free_id); end
            end
        end
        n_cmp++; if (rob_if.rob_full !== 1'b1) begin n_err++; $display("FAIL fw_full got=%b exp=1", rob_if.rob_full); end
        set_alloc(2'd0, 5'd31, 32'h999, 1'b1);
        tick();
        idle();
        rob_if.qry1_id = 4'd3;
        #1;
        n_cmp++; if (rob_if.rob_full !== 1'b1 || rob_if.rob_free_id !== 4'd3) begin n_err++; $display("FAIL fw_extra_ignored got=%b/%0d exp=1/3", rob_if.rob_full, rob_if.rob_free_id); end
        n_cmp++; if (rob_if.qry1_ready !== 1'b0) begin n_err++; $display("FAIL fw_head_not_overwritten got=%b exp=0", rob_if.qry1_ready); end
        rob_if.rs_valid = 1'b1; rob_if.rs_id = 4'd3; rob_if.rs_value = 32'h33;
        tick();
        idle();
        n_cmp++; if (rob_if.rob_full !== 1'b1) begin n_err++; $display("FAIL fw_full_before_commit got=%b exp=1", rob_if.rob_full); end
        tick();
        n_cmp++; if (rob_if.commit_valid !== 1'b1 || rob_if.commit_id !== 4'd3 || rob_if.commit_value !== 32'h33) begin n_err++; $display("FAIL fw_commit3 got=%b/%0d/%h exp=1/3/33", rob_if.commit_valid, rob_if.commit_id, rob_if.commit_value); end
        n_cmp++; if (rob_if.rob_full !== 1'b0 || rob_if.rob_free_id !== 4'd3) begin n_err++; $display("FAIL fw_freed got=%b/%0d exp=0/3", rob_if.rob_full, rob_if.rob_free_id); end
        set_alloc(2'd0, 5'd20, 32'h0, 1'b0);
        tick();
        idle();
        n_cmp++; if (rob_if.rob_full !== 1'b1 || rob_if.rob_free_id !== 4'd4) begin n_err++; $display("FAIL fw_refill got=%b/%0d exp=1/4", rob_if.rob_full, rob_if.rob_free_id); end
    endtask

    task automatic test_reset_mid;
        rob_if.rs_valid = 1'b1; rob_if.rs_id = 4'd4; rob_if.rs_value = 32'h1;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        idle();
        n_cmp++; if (rob_if.rob_full !== 1'b0 || rob_if.rob_free_id !== 4'd0) begin n_err++; $display("FAIL rm_cleared got=%b/%0d exp=0/0", rob_if.rob_full, rob_if.rob_free_id); end
        tick();
        n_cmp++; if (rob_if.commit_valid !== 1'b0) begin n_err++; $display("FAIL rm_no_commit got=%b exp=0", rob_if.commit_valid); end
    endtask

    task automatic test_bypass;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_alloc(2'd0, 5'(i + 1), 32'h0, 1'b0);
            tick();
        end
        idle();
        rob_if.qry1_id = 4'd3;
        rob_if.rs_valid = 1'b1; rob_if.rs_id = 4'd3; rob_if.rs_value = 32'hDEAD;
        rob_if.qry2_id = 4'd2;
        rob_if.lsb_valid = 1'b1; rob_if.lsb_id = 4'd2; rob_if.lsb_value = 32'hBEEF;
        #1;
        n_cmp++; if (rob_if.qry1_ready !== 1'b1 || rob_if.qry1_value !== 32'hDEAD) begin n_err++; $display("FAIL byp_rs got=%b/%h exp=1/dead", rob_if.qry1_ready, rob_if.qry1_value); end
        n_cmp++; if (rob_if.qry2_ready !== 1'b1 || rob_if.qry2_value !== 32'hBEEF) begin n_err++; $display("FAIL byp_lsb got=%b/%h exp=1/beef", rob_if.qry2_ready, rob_if.qry2_value); end
        tick();
        idle();
        rob_if.qry1_id = 4'd3;
        rob_if.qry2_id = 4'd1;
        #1;
        n_cmp++; if (rob_if.qry1_ready !== 1'b1 || rob_if.qry1_value !== 32'hDEAD) begin n_err++; $display("FAIL byp_stored got=%b/%h exp=1/dead", rob_if.qry1_ready, rob_if.qry1_value); end
        n_cmp++; if (rob_if.qry2_ready !== 1'b0) begin n_err++; $display("FAIL byp_pending got=%b exp=0", rob_if.qry2_ready); end
        rob_if.lsb_valid = 1'b1; rob_if.lsb_id = 4'd3; rob_if.lsb_value = 32'h1234;
        #1;
        n_cmp++; if (rob_if.qry1_value !== 32'h1234) begin n_err++; $display("FAIL byp_bus_priority got=%h exp=1234", rob_if.qry1_value); end
        idle();
    endtask

    task automatic test_branch_mispredict;
        do_reset();
        set_alloc(2'd2, 5'd0, 32'h100, 1'b0);
        tick();
        set_alloc(2'd0, 5'd7, 32'h0, 1'b0);
        tick();
        set_alloc(2'd0, 5'd8, 32'h77, 1'b1);
        rob_if.rs_valid = 1'b1; rob_if.rs_id = 4'd0; rob_if.rs_value = 32'h200;
        tick();
        idle();
        tick();
        n_cmp++; if (rob_if.commit_valid !== 1'b1 || rob_if.commit_id !== 4'd0 || rob_if.commit_value !== 32'h200) begin n_err++; $display("FAIL br_commit got=%b/%0d/%h exp=1/0/200", rob_if.commit_valid, rob_if.commit_id, rob_if.commit_value); end
        n_cmp++; if (rob_if.rob_clear !== 1'b1 || rob_if.clear_pc !== 32'h200) begin n_err++; $display("FAIL br_clear got=%b/%h exp=1/200", rob_if.rob_clear, rob_if.clear_pc); end
        n_cmp++; if (rob_if.rob_free_id !== 4'd0 || rob_if.rob_full !== 1'b0) begin n_err++; $display("FAIL br_flushed got=%0d/%b exp=0/0", rob_if.rob_free_id, rob_if.rob_full); end
        set_alloc(2'd0, 5'd9, 32'h9, 1'b1);
        rob_if.rs_valid = 1'b1; rob_if.rs_id = 4'd1; rob_if.rs_value = 32'h5;
        tick();
        idle();
        rob_if.qry1_id = 4'd1;
        #1;
        n_cmp++; if (rob_if.rob_clear !== 1'b0 || rob_if.commit_valid !== 1'b0) begin n_err++; $display("FAIL br_pulse_single got=%b/%b exp=0/0", rob_if.rob_clear, rob_if.commit_valid); end
        n_cmp++; if (rob_if.rob_free_id !== 4'd0) begin n_err++; $display("FAIL br_alloc_suppressed got=%0d exp=0", rob_if.rob_free_id); end
        n_cmp++; if (rob_if.qry1_ready !== 1'b0) begin n_err++; $display("FAIL br_wb_suppressed got=%b exp=0", rob_if.qry1_ready); end
        rob_if.rs_valid = 1'b1; rob_if.rs_id = 4'd2; rob_if.rs_value = 32'h66;
        tick();
        idle();
        rob_if.qry2_id = 4'd2;
        #1;
        n_cmp++; if (rob_if.qry2_ready !== 1'b0 || rob_if.commit_valid !== 1'b0) begin n_err++; $display("FAIL br_old_id_ignored got=%b/%b exp=0/0", rob_if.qry2_ready, rob_if.commit_valid); end
    endtask

    task automatic test_branch_ok_halt;
        do_reset();
        set_alloc(2'd2, 5'd0, 32'h300, 1'b0);
        tick();
        set_alloc(2'd3, 5'd0, 32'h0, 1'b1);
        rob_if.rs_valid = 1'b1; rob_if.rs_id = 4'd0; rob_if.rs_value = 32'h300;
        tick();
        idle();
        set_alloc(2'd0, 5'd9, 32'h9, 1'b1);
        tick();
        idle();
        n_cmp++; if (rob_if.commit_valid !== 1'b1 || rob_if.commit_id !== 4'd0 || rob_if.rob_clear !== 1'b0) begin n_err++; $display("FAIL ok_branch got=%b/%0d/%b exp=1/0/0", rob_if.commit_valid, rob_if.commit_id, rob_if.rob_clear); end
        n_cmp++; if (rob_if.rob_free_id !== 4'd3) begin n_err++; $display("FAIL ok_free_id got=%0d exp=3", rob_if.rob_free_id); end
        tick();
        n_cmp++; if (rob_if.commit_valid !== 1'b1 || rob_if.commit_id !== 4'd1 || rob_if.halt !== 1'b1) begin n_err++; $display("FAIL halt_commit got=%b/%0d/%b exp=1/1/1", rob_if.commit_valid, rob_if.commit_id, rob_if.halt); end
        tick();
        n_cmp++; if (rob_if.commit_valid !== 1'b0 || rob_if.halt !== 1'b1) begin n_err++; $display("FAIL halt_stops got=%b/%b exp=0/1", rob_if.commit_valid, rob_if.halt); end
        tick();
        n_cmp++; if (rob_if.commit_valid !== 1'b0 || rob_if.halt !== 1'b1) begin n_err++; $display("FAIL halt_sticky got=%b/%b exp=0/1", rob_if.commit_valid, rob_if.halt); end
    endtask

    task automatic test_rdy_stall;
        do_reset();
        #1;
        n_cmp++; if (rob_if.halt !== 1'b0) begin n_err++; $display("FAIL stall_halt_reset got=%b exp=0", rob_if.halt); end
        set_alloc(2'd0, 5'd3, 32'h42, 1'b1);
        tick();
        rdy = 1'b0;
        set_alloc(2'd0, 5'd4, 32'h43, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (rob_if.commit_valid !== 1'b0 || rob_if.rob_free_id !== 4'd1) begin n_err++; $display("FAIL stall_hold_%0d got=%b/%0d exp=0/1", i, rob_if.commit_valid, rob_if.rob_free_id); end
        end
        rdy = 1'b1;
        idle();
        tick();
        n_cmp++; if (rob_if.commit_valid !== 1'b1 || rob_if.commit_id !== 4'd0 || rob_if.commit_value !== 32'h42) begin n_err++; $display("FAIL stall_commit got=%b/%0d/%h exp=1/0/42", rob_if.commit_valid, rob_if.commit_id, rob_if.commit_value); end
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (rob_if.commit_valid !== 1'b1 || rob_if.commit_rd !== 5'd3) begin n_err++; $display("FAIL stall_pulse_kept_%0d got=%b/%0d exp=1/3", i, rob_if.commit_valid, rob_if.commit_rd); end
        end
        rdy = 1'b1;
        tick();
        n_cmp++; if (rob_if.commit_valid !== 1'b0 || rob_if.rob_free_id !== 4'd1) begin n_err++; $display("FAIL stall_release got=%b/%0d exp=0/1", rob_if.commit_valid, rob_if.rob_free_id); end
    endtask

    initial begin
        rst = 1'b0;
        rdy = 1'b1;
        idle();
        test_reset();
        test_alloc_commit();
        test_ooo_writeback();
        test_full_wrap();
        test_reset_mid();
        test_bypass();
        test_branch_mispredict();
        test_branch_ok_halt();
        test_rdy_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
